// File: rtl/tt_adder_pkg.sv
// tt_adder_pkg: shared FSM states, counter sizing and width limits for the serial adder.
package tt_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // Bits needed to count 0..n-1; never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/tt_full_adder_cell.sv
// tt_full_adder_cell: one-bit full adder, the single arithmetic cell of the serial adder.
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry out
module tt_full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/tt_serial_adder.sv
// tt_serial_adder: LSB-first bit-serial add/subtract of two WIDTH-bit operands.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake (a, b, sub sampled on accept)
//   out_valid, out_ready : result handshake (sum, carry_out, overflow)
//   busy                 : high while bits are being processed
module tt_serial_adder
    import tt_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = clog2(WIDTH);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("tt_serial_adder: WIDTH out of range");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, ovf_q, ovf_d;
    logic             fa_s, fa_c, last;

    tt_full_adder_cell u_fa (
        .a   (op_a_q[0]),
        .b   (op_b_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .cout(fa_c)
    );

    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                // Subtract as a + ~b + 1, the +1 entering as the initial carry.
                op_a_d  = a;
                op_b_d  = sub ? ~b : b;
                carry_d = sub;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    // carry_q is still the carry into the MSB here.
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q == RUN;
    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_tt_serial_adder.sv
// tb_tt_serial_adder: directed checks of the serial adder at WIDTH 8, 2 and 32.
module tb_tt_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic        iv8, ir8, s8, ov8, or8, co8, of8, bz8;
    logic [7:0]  a8, b8, sum8;
    logic        iv2, ir2, s2, ov2, or2, co2, of2, bz2;
    logic [1:0]  a2, b2, sum2;
    logic        iv32, ir32, s32, ov32, or32, co32, of32, bz32;
    logic [31:0] a32, b32, sum32;

    tt_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(s8),
        .out_valid(ov8), .out_ready(or8), .sum(sum8), .carry_out(co8), .overflow(of8), .busy(bz8)
    );
    tt_serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .sub(s2),
        .out_valid(ov2), .out_ready(or2), .sum(sum2), .carry_out(co2), .overflow(of2), .busy(bz2)
    );
    tt_serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .sub(s32),
        .out_valid(ov32), .out_ready(or32), .sum(sum32), .carry_out(co32), .overflow(of32), .busy(bz32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Wide-add reference: {overflow, carry_out, sum}.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [32:0] m, bb, f;
        m  = (33'd1 << w) - 33'd1;
        bb = (s ? ~{1'b0, b} : {1'b0, b}) & m;
        f  = ({1'b0, a} & m) + bb + {32'd0, s};
        return {(a[w-1] == bb[w-1]) && (f[w-1] != a[w-1]), f[w], f[31:0] & m[31:0]};
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [7:0] es,
                       input logic ec, input logic eo, input bit hold, input string tag);
        int cyc;
        check({tag, " in_ready_idle"}, ir8, 1);
        a8 = a; b8 = b; s8 = s; iv8 = 1;
        @(posedge clk); @(negedge clk);
        iv8 = 0; cyc = 0;
        while (!ov8 && cyc < 20) begin
            if (ir8 !== 1'b0 || bz8 !== 1'b1) check({tag, " run_ready_busy"}, {ir8, bz8}, 2'b01);
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, 8);
        check({tag, " in_ready_done"}, ir8, 0);
        check({tag, " sum"}, sum8, es);
        check({tag, " carry"}, co8, ec);
        check({tag, " ovf"}, of8, eo);
        if (hold) begin
            a8 = 8'h33; b8 = 8'h44; s8 = 0; iv8 = 1;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); @(negedge clk);
                check({tag, " hold_result"}, {ov8, ir8, co8, of8, sum8}, {2'b10, ec, eo, es});
            end
            iv8 = 0;
        end
        or8 = 1;
        @(posedge clk); @(negedge clk);
        or8 = 0;
        check({tag, " back_idle"}, {ov8, ir8}, 2'b01);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic s, input logic [1:0] es,
                       input logic ec, input logic eo, input string tag);
        int cyc = 0;
        a2 = a; b2 = b; s2 = s; iv2 = 1;
        @(posedge clk); @(negedge clk);
        iv2 = 0;
        while (!ov2 && cyc < 10) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, 2);
        check({tag, " result"}, {eo, ec, sum2}, {eo, ec, es});
        check({tag, " flags"}, {of2, co2}, {eo, ec});
        or2 = 1;
        @(posedge clk); @(negedge clk);
        or2 = 0;
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [31:0] es,
                        input logic ec, input logic eo, input string tag);
        int cyc = 0;
        a32 = a; b32 = b; s32 = s; iv32 = 1;
        @(posedge clk); @(negedge clk);
        iv32 = 0;
        while (!ov32 && cyc < 40) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, 32);
        check({tag, " sum"}, sum32, es);
        check({tag, " flags"}, {of32, co32}, {eo, ec});
        or32 = 1;
        @(posedge clk); @(negedge clk);
        or32 = 0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [33:0] e;
        rst = 1;
        {iv8, s8, or8, a8, b8} = '0;
        {iv2, s2, or2, a2, b2} = '0;
        {iv32, s32, or32, a32, b32} = '0;
        repeat (2) @(negedge clk);
        check("reset8", {ir8, ov8, bz8, co8, of8, sum8}, {5'b10000, 8'h00});
        check("reset32", {ir32, ov32, bz32, co32, of32, sum32}, {5'b10000, 32'h0});
        rst = 0;
        @(negedge clk);

        op8(8'h0F, 8'h01, 0, 8'h10, 0, 0, 0, "add_0f_01");
        op8(8'hFF, 8'h01, 0, 8'h00, 1, 0, 0, "add_ff_01");
        op8(8'h7F, 8'h01, 0, 8'h80, 0, 1, 0, "add_7f_01");
        op8(8'h05, 8'h07, 1, 8'hFE, 0, 0, 0, "sub_05_07");
        op8(8'h80, 8'h01, 1, 8'h7F, 1, 1, 1, "sub_80_01_bp");
        op8(8'h12, 8'h34, 0, 8'h46, 0, 0, 0, "after_bp");

        a8 = 8'hAA; b8 = 8'h55; s8 = 0; iv8 = 1;
        @(posedge clk); @(negedge clk);
        iv8 = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1 check("mid_run_reset", {ir8, ov8, bz8, co8, of8, sum8}, {5'b10000, 8'h00});
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("after_reset_idle", {ir8, bz8}, 2'b10);
        op8(8'h01, 8'h02, 0, 8'h03, 0, 0, 0, "post_reset_add");

        op2(2'd3, 2'd3, 0, 2'd2, 1, 0, "w2_ones");
        op2(2'd1, 2'd1, 0, 2'd2, 0, 1, "w2_ovf");
        op2(2'd2, 2'd1, 1, 2'd1, 1, 1, "w2_sub");
        op32(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 1, 0, "w32_ones");
        op32(32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1, "w32_ovf");
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            e = model(2, ra & 32'h3, rb & 32'h3, rs);
            op2(ra[1:0], rb[1:0], rs, e[1:0], e[32], e[33], "w2_rand");
            e = model(32, ra, rb, rs);
            op32(ra, rb, rs, e[31:0], e[32], e[33], "w32_rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
